trace_stream_serializer: RTL

Egress end of the trace path. Pops 256-bit trace records (tx_id | t_ingress | t_egress | flags | opcode | meta) from the trace FIFO read side. Serializes each record into fixed-width AXI-Stream beats for the host readout link. Keeps saturating statistics for emitted records and error-flagged records.

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_sat_counter.sv | 16 +
 rtl/trace_stream_serializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: trace record layout and serializer constants shared by the trace egress path
package trace_pkg;

   localparam int TRACE_RECORD_WIDTH = 256;

   localparam int FLAG_CORE_ERROR = 1;
   localparam int TRACE_SER_FLAG_ERR_BIT = FLAG_CORE_ERROR;

   // flags sits directly above opcode(16) and meta(32) in the packed record
   localparam int TRACE_FLAGS_LSB = 48;

   localparam logic [15:0] TRACE_SER_MAGIC = 16'h5E47;

   typedef struct packed {
      logic [63:0] tx_id;
      logic [63:0] t_ingress;
      logic [63:0] t_egress;
      logic [15:0] flags;
      logic [15:0] opcode;
      logic [31:0] meta;
   } trace_record_t;

   typedef enum logic {SER_IDLE, SER_SEND} trace_ser_state_e;

endpackage

// File: rtl/trace_sat_counter.sv
// trace_sat_counter: up-counter that sticks at all-ones instead of wrapping
module trace_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Advance on inc until every bit is set, then hold
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (inc && count != '1) count <= count + WIDTH'(1);

endmodule

// File: rtl/trace_stream_serializer.sv
// trace_stream_serializer: slices 256-bit trace records into MSB-first stream beats (optional header via TRACE_SER_HEADER_EN)
module trace_stream_serializer
   import trace_pkg::*;
#(
   parameter int OUT_WIDTH = 64,
   parameter int CNT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rec_valid,
   output logic                          rec_ready,
   input  logic [TRACE_RECORD_WIDTH-1:0] rec_data,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [OUT_WIDTH-1:0]          m_tdata,
   output logic                          m_tlast,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          records_sent,
   output logic [CNT_WIDTH-1:0]          err_records
);

   localparam int BEATS = TRACE_RECORD_WIDTH / OUT_WIDTH;
`ifdef TRACE_SER_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int TOTAL = BEATS + HDR;
   localparam int IW = $clog2(TOTAL);
   localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

   if (OUT_WIDTH != 32 && OUT_WIDTH != 64 && OUT_WIDTH != 128) begin : g_bad_width
      $error("trace_stream_serializer: OUT_WIDTH must be 32, 64 or 128");
   end

   trace_ser_state_e state, state_n;
   logic [IW-1:0] idx, idx_n, pidx;
   logic [TRACE_RECORD_WIDTH-1:0] hold;
   logic [OUT_WIDTH-1:0] beat;
   logic accept, last_hs;

`ifdef TRACE_SER_HEADER_EN
   logic [15:0] seq, hdr_seq;

   // Stamp each accepted record with the running sequence number, then advance (wraps at 16 bits)
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         seq <= '0;
         hdr_seq <= '0;
      end else if (accept) begin
         hdr_seq <= seq;
         seq <= seq + 16'd1;
      end
`endif

   // Handshake and next-state: the final beat's handshake frees the slot so a new record can follow with no bubble
   always_comb begin
      state_n = state;
      idx_n = idx;
      m_tvalid = state == SER_SEND;
      m_tlast = m_tvalid && idx == LAST;
      last_hs = m_tlast && m_tready;
      rec_ready = state == SER_IDLE || last_hs;
      accept = rec_valid && rec_ready;
      if (accept) begin
         state_n = SER_SEND;
         idx_n = '0;
      end else if (last_hs) begin
         state_n = SER_IDLE;
         idx_n = '0;
      end else if (m_tvalid && m_tready) idx_n = idx + IW'(1);
   end

   // Beat selection: payload words leave MSB first, the optional header occupies slot 0
   always_comb begin
      pidx = idx < IW'(HDR) ? '0 : idx - IW'(HDR);
      beat = hold[TRACE_RECORD_WIDTH - 1 - int'(pidx) * OUT_WIDTH -: OUT_WIDTH];
`ifdef TRACE_SER_HEADER_EN
      if (idx == '0) begin
         beat = '0;
         beat[OUT_WIDTH-1 -: 16] = TRACE_SER_MAGIC;
         beat[15:0] = hdr_seq;
      end
`endif
      m_tdata = m_tvalid ? beat : '0;
   end

   // State, beat index and the record holding register; a reset mid-record simply drops the held record
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= SER_IDLE;
         idx <= '0;
         hold <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         if (accept) hold <= rec_data;
      end

   assign busy = state == SER_SEND;

   trace_sat_counter #(.WIDTH(CNT_WIDTH)) u_sent (
      .clk(clk),
      .rst_n(rst_n),
      .inc(last_hs),
      .count(records_sent)
   );

   trace_sat_counter #(.WIDTH(CNT_WIDTH)) u_err (
      .clk(clk),
      .rst_n(rst_n),
      .inc(accept && rec_data[TRACE_FLAGS_LSB + TRACE_SER_FLAG_ERR_BIT]),
      .count(err_records)
   );

endmodule
